inst_buffer: RTL and testbench

Instruction queue between fetch (IF) and decode (ID). It accepts packets of up to `FETCH_WIDTH` fetched instructions per cycle and presents the oldest up to `DECODE_WIDTH` instructions to decode. It retires them when decode is not stalled, and empties on a pipeline clear. It is the producing end of the decode stage's stall/clear interface: it holds instructions steady while `stall` is high and discards them on `clear`, the same way the downstream ID→RR register does.

---
 rtl/inst_buffer.sv | 112 +++++++++++
 tb/tb_inst_buffer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/inst_buffer.sv
// Fetch-to-decode instruction queue: circular {pc, inst} store, contiguous-prefix
// multi-lane push, all-or-nothing multi-lane pop, synchronous clear.

module inst_buffer_lane #(
  parameter int DEPTH = 16,
  parameter int LANE  = 0
) (
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [$clog2(DEPTH+1)-1:0] count,
  input  logic [DEPTH-1:0][31:0]     mem_pc,
  input  logic [DEPTH-1:0][31:0]     mem_inst,
  output logic                       valid,
  output logic [31:0]                pc,
  output logic [31:0]                inst
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] idx;

  assign idx   = head + AW'(LANE);
  assign valid = count > CW'(LANE);
  assign pc    = mem_pc[idx];
  assign inst  = mem_inst[idx];
endmodule

module inst_buffer #(
  parameter int FETCH_WIDTH  = 4,
  parameter int DECODE_WIDTH = 4,
  parameter int DEPTH        = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                clear,
  input  logic                                stall,
  input  logic [FETCH_WIDTH-1:0]              in_valid,
  input  logic [FETCH_WIDTH-1:0][31:0]        in_pc,
  input  logic [FETCH_WIDTH-1:0][31:0]        in_inst,
  output logic                                in_ready,
  output logic [DECODE_WIDTH-1:0]             out_valid,
  output logic [DECODE_WIDTH-1:0][31:0]       out_pc,
  output logic [DECODE_WIDTH-1:0][31:0]       out_inst,
  output logic [$clog2(DEPTH+1)-1:0]          count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] RDY_MAX = CW'(DEPTH - FETCH_WIDTH);
  localparam logic [CW-1:0] DW_C    = CW'(DECODE_WIDTH);

  logic [DEPTH-1:0][31:0]   mem_pc, mem_inst;
  logic [AW-1:0]            head, tail;
  logic [FETCH_WIDTH-1:0]   wr_en;
  logic [CW-1:0]            k, n;
  logic                     push, pop, run;

  // Lanes past the first invalid one are ignored, so wr_en is a thermometer prefix.
  always_comb begin
    run   = 1'b1;
    k     = '0;
    wr_en = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      run      = run & in_valid[i];
      wr_en[i] = run;
      k        = k + {{(CW-1){1'b0}}, run};
    end
  end

  assign in_ready = (count <= RDY_MAX);
  assign push     = in_ready && (|in_valid) && !clear;
  assign pop      = !stall && !clear;
  assign n        = (count < DW_C) ? count : DW_C;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(k);
      if (pop)  head <= head + AW'(n);
      count <= count + (push ? k : '0) - (pop ? n : '0);
    end
  end

  // Entry storage carries no reset; out_valid masks stale contents.
  always_ff @(posedge clock) begin
    if (push) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (wr_en[i]) begin
          mem_pc[tail + AW'(i)]   <= in_pc[i];
          mem_inst[tail + AW'(i)] <= in_inst[i];
        end
      end
    end
  end

  for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_lane
    inst_buffer_lane #(.DEPTH(DEPTH), .LANE(g)) u_lane (
      .head     (head),
      .count    (count),
      .mem_pc   (mem_pc),
      .mem_inst (mem_inst),
      .valid    (out_valid[g]),
      .pc       (out_pc[g]),
      .inst     (out_inst[g])
    );
  end
endmodule

// File: tb/tb_inst_buffer.sv
// Bench for inst_buffer: hand-derived vector table, hand sequences for reset,
// and randomized traffic checked against a queue-based reference model.

module tb_inst_buffer;
  localparam int FW = 4;
  localparam int DW = 4;
  localparam int DEPTH = 16;

  logic                clock, reset, clear, stall;
  logic [FW-1:0]       in_valid;
  logic [FW-1:0][31:0] in_pc, in_inst;
  logic                in_ready;
  logic [DW-1:0]       out_valid;
  logic [DW-1:0][31:0] out_pc, out_inst;
  logic [4:0]          count;

  inst_buffer #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .clear(clear), .stall(stall),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_inst(out_inst), .count(count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t q[$];

  typedef struct {
    logic clr; logic stl; logic [3:0] vld; logic [31:0] base;
    int cnt; bit rdy; logic [31:0] pc0;
  } vec_t;
  vec_t tbl[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of entries; ready and pop size use the pre-edge occupancy.
  task automatic model_edge();
    int sz, nn, kk;
    bit rdy;
    sz = q.size();
    if (clear) begin
      q.delete();
      return;
    end
    rdy = (DEPTH - sz) >= FW;
    nn  = stall ? 0 : ((sz < DW) ? sz : DW);
    kk  = 0;
    while (kk < FW && in_valid[kk]) kk++;
    for (int i = 0; i < nn; i++) void'(q.pop_front());
    if (rdy) for (int i = 0; i < kk; i++) q.push_back('{in_pc[i], in_inst[i]});
  endtask

  task automatic model_check();
    logic [3:0] ov;
    int sz;
    sz = q.size();
    for (int i = 0; i < DW; i++) ov[i] = (i < sz);
    chk("m_count", 32'(count), 32'(sz));
    chk("m_in_ready", 32'(in_ready), 32'((DEPTH - sz) >= FW));
    chk("m_out_valid", 32'(out_valid), 32'(ov));
    for (int i = 0; i < DW && i < sz; i++) begin
      chk("m_lane_pc", out_pc[i], q[i].pc);
      chk("m_lane_inst", out_inst[i], q[i].inst);
    end
  endtask

  task automatic cyc(input logic clr, input logic stl, input logic [3:0] vld,
                     input logic [31:0] base, input bit rnd);
    clear = clr; stall = stl; in_valid = vld;
    for (int i = 0; i < FW; i++) begin
      in_pc[i]   = base + 32'(4 * i);
      in_inst[i] = rnd ? $urandom : (in_pc[i] ^ 32'hA5A5_0000);
    end
    @(posedge clock);
    model_edge();
    #1;
    model_check();
  endtask

  initial begin
    logic [3:0] eov;
    int m;
    reset = 1'b0; clear = 1'b0; stall = 1'b0;
    in_valid = '0; in_pc = '0; in_inst = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    reset = 1'b1;

    //           clr   stl   vld    base          cnt rdy  pc0
    tbl.push_back('{1'b0, 1'b0, 4'hF, 32'h100,  4,  1, 32'h100});
    tbl.push_back('{1'b0, 1'b0, 4'h0, 32'h0,    0,  1, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 4'hF, 32'h200,  4,  1, 32'h200});
    tbl.push_back('{1'b0, 1'b1, 4'hF, 32'h300,  8,  1, 32'h200});
    tbl.push_back('{1'b0, 1'b1, 4'hF, 32'h400, 12,  1, 32'h200});
    tbl.push_back('{1'b0, 1'b1, 4'hF, 32'h500, 16,  0, 32'h200});
    tbl.push_back('{1'b0, 1'b1, 4'hF, 32'h600, 16,  0, 32'h200});
    tbl.push_back('{1'b0, 1'b0, 4'h0, 32'h0,   12,  1, 32'h300});
    tbl.push_back('{1'b1, 1'b0, 4'hF, 32'h700,  0,  1, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 4'hB, 32'h800,  2,  1, 32'h800});
    tbl.push_back('{1'b0, 1'b1, 4'h1, 32'h900,  3,  1, 32'h800});
    tbl.push_back('{1'b0, 1'b1, 4'hE, 32'hA00,  3,  1, 32'h800});
    tbl.push_back('{1'b0, 1'b0, 4'hF, 32'hB00,  4,  1, 32'hB00});
    tbl.push_back('{1'b0, 1'b0, 4'h0, 32'h0,    0,  1, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 32'h0,    0,  1, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 4'hF, 32'h1000, 4,  1, 32'h1000});
    tbl.push_back('{1'b0, 1'b1, 4'hF, 32'h1100, 8,  1, 32'h1000});
    tbl.push_back('{1'b0, 1'b1, 4'hF, 32'h1200,12,  1, 32'h1000});
    tbl.push_back('{1'b0, 1'b1, 4'h3, 32'h1300,14,  0, 32'h1000});
    tbl.push_back('{1'b0, 1'b0, 4'h0, 32'h0,   10,  1, 32'h1100});
    tbl.push_back('{1'b0, 1'b0, 4'h0, 32'h0,    6,  1, 32'h1200});
    tbl.push_back('{1'b0, 1'b0, 4'h0, 32'h0,    2,  1, 32'h1300});
    tbl.push_back('{1'b0, 1'b0, 4'h0, 32'h0,    0,  1, 32'h0});
    // head now sits at 14: the next six entries span 14..3
    tbl.push_back('{1'b0, 1'b1, 4'hF, 32'hC00,  4,  1, 32'hC00});
    tbl.push_back('{1'b0, 1'b1, 4'h3, 32'hD00,  6,  1, 32'hC00});
    tbl.push_back('{1'b0, 1'b0, 4'h0, 32'h0,    2,  1, 32'hD00});
    tbl.push_back('{1'b0, 1'b0, 4'h0, 32'h0,    0,  1, 32'h0});

    foreach (tbl[r]) begin
      cyc(tbl[r].clr, tbl[r].stl, tbl[r].vld, tbl[r].base, 1'b0);
      m = (tbl[r].cnt < DW) ? tbl[r].cnt : DW;
      for (int i = 0; i < DW; i++) eov[i] = (i < m);
      chk("tbl_count", 32'(count), 32'(tbl[r].cnt));
      chk("tbl_in_ready", 32'(in_ready), 32'(tbl[r].rdy));
      chk("tbl_out_valid", 32'(out_valid), 32'(eov));
      if (tbl[r].cnt > 0) chk("tbl_pc0", out_pc[0], tbl[r].pc0);
    end

    // Asynchronous reset in the middle of a cycle with 7 entries held.
    cyc(1'b1, 1'b1, 4'h0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 4'hF, 32'h2000, 1'b0);
    cyc(1'b0, 1'b1, 4'h7, 32'h2100, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd7);
    in_valid = '0;
    #2 reset = 1'b0;
    #1;
    q.delete();
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_count", 32'(count), 32'd0);

    for (int c = 0; c < 400; c++) begin
      logic rclr, rstl;
      logic [3:0] rv;
      rclr = ($urandom_range(0, 19) == 0);
      rstl = ($urandom_range(0, 2) == 0);
      rv   = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      cyc(rclr, rstl, rv, $urandom, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
